// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths common to both ends of the bus and the
// completer state encoding.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 16;
  localparam int unsigned APB_DATA_W = 16;
  localparam int unsigned ERR_CNT_W  = 8;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } apb_rsp_state_t;

endpackage

// File: rtl/apb_resp_mem.sv
// Single-port synchronous RAM: one read or one write per cycle, registered read.
module apb_resp_mem #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/apb_mem_responder.sv
// APB completer for a word-addressed memory window with programmable wait
// states, PSLVERR on out-of-window addresses and a saturating error counter.
module apb_mem_responder
  import apb_pkg::*;
#(
  parameter int unsigned       ADDR_W      = APB_ADDR_W,
  parameter int unsigned       DATA_W      = APB_DATA_W,
  parameter int unsigned       DEPTH       = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h1000,
  parameter int unsigned       WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    paddr,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [DATA_W-1:0]    pwdata,
  output logic [DATA_W-1:0]    prdata,
  output logic                 pready,
  output logic                 pslverr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  // Window bounds carried one bit wider so a window ending at the top of the
  // address space does not wrap around to low addresses.
  localparam logic [ADDR_W:0]         WIN_LO  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0]         WIN_HI  = WIN_LO + (ADDR_W+1)'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0]   WAIT_LD = WAIT_CNT_W'(WAIT_STATES);

  apb_rsp_state_t r_state, w_next;

  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_wr;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_in_range;
  logic                  r_rd_valid;
  logic [ERR_CNT_W-1:0]  r_err_cnt;

  logic [ADDR_W:0]   w_paddr_x;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic              w_setup;
  logic              w_resp;
  logic              w_mem_we;
  logic              w_mem_re;
  logic [IDX_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0] w_mem_rdata;

  assign w_paddr_x  = {1'b0, paddr};
  assign w_in_range = (w_paddr_x >= WIN_LO) && (w_paddr_x < WIN_HI);
  assign w_idx      = IDX_W'(paddr - BASE_ADDR);
  assign w_setup    = (r_state == IDLE) && psel && !penable;
  assign w_resp     = (r_state == RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_setup) w_next = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT: begin
        if (!psel)                             w_next = IDLE;
        else if (r_cnt == WAIT_CNT_W'(1))      w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_wr       <= 1'b0;
      r_wdata    <= '0;
      r_in_range <= 1'b0;
      r_rd_valid <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      if (w_setup) begin
        r_cnt      <= WAIT_LD;
        r_idx      <= w_idx;
        r_wr       <= pwrite;
        r_wdata    <= pwdata;
        r_in_range <= w_in_range;
        if (!pwrite) r_rd_valid <= w_in_range;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - WAIT_CNT_W'(1);
      end
      if (pslverr && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  // The RAM read register is only loaded by in-window reads; r_rd_valid forces
  // zero after reset and after an out-of-window read without touching the RAM.
  assign w_mem_we   = w_resp && psel && penable && r_wr && r_in_range;
  assign w_mem_re   = w_setup && !pwrite && w_in_range;
  assign w_mem_addr = w_resp ? r_idx : w_idx;

  apb_resp_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (w_mem_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  assign prdata  = r_rd_valid ? w_mem_rdata : '0;
  assign pready  = w_resp;
  assign pslverr = w_resp && !r_in_range;
  assign err_cnt = r_err_cnt;

endmodule
